// File: rtl/logic_unit_pkg.sv
// rtl/logic_unit_pkg.sv - opcode encoding and reserved-opcode test for the registered logic unit
package logic_unit_pkg;

  localparam int unsigned OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NAND = 3'd0,
    OP_INV  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_XOR  = 3'd4,
    OP_PASS = 3'd5
  } op_e;

  function automatic logic is_reserved(input logic [OP_W-1:0] op);
    return (op > 3'd5);
  endfunction

endpackage

// File: rtl/logic_unit_comb.sv
// rtl/logic_unit_comb.sv - combinational WIDTH-bit gate set: (op, a, b) -> (res, err)
module logic_unit_comb
  import logic_unit_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [OP_W-1:0]  op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic [WIDTH-1:0] res_o,
  output logic             err_o
);

  always_comb begin
    res_o = '0;
    err_o = is_reserved(op_i);
    case (op_i)
      OP_NAND: res_o = ~(a_i & b_i);
      OP_INV:  res_o = ~a_i;
      OP_AND:  res_o = a_i & b_i;
      OP_OR:   res_o = a_i | b_i;
      OP_XOR:  res_o = a_i ^ b_i;
      OP_PASS: res_o = b_i;
      default: res_o = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_reg.sv
// rtl/logic_unit_reg.sv - registered logic unit with handshake, one-entry output and accumulator
// Optional saturating op/error counters under LOGIC_UNIT_REG_STATS_EN.
module logic_unit_reg
  import logic_unit_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter logic [WIDTH-1:0] ACC_INIT = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic             in_use_acc,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_res,
  output logic             out_zero,
  output logic             out_err,
  output logic [WIDTH-1:0] acc
`ifdef LOGIC_UNIT_REG_STATS_EN
  ,
  output logic [15:0]      stat_ops,
  output logic [15:0]      stat_err
`endif
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             err_q, err_d;
  logic [WIDTH-1:0] acc_q, acc_d;

  logic             accept;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] comb_res;
  logic             comb_err;

  assign in_ready = !valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign op_a     = in_use_acc ? acc_q : in_a;

  logic_unit_comb #(.WIDTH(WIDTH)) u_comb (
    .op_i  (in_op),
    .a_i   (op_a),
    .b_i   (in_b),
    .res_o (comb_res),
    .err_o (comb_err)
  );

  always_comb begin
    valid_d = valid_q;
    res_d   = res_q;
    zero_d  = zero_q;
    err_d   = err_q;
    if (accept) begin
      valid_d = 1'b1;
      res_d   = comb_res;
      zero_d  = (comb_res == '0);
      err_d   = comb_err;
    end else if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
  end

  // Clear wins over the accept's update; the accepted op already read the old value.
  always_comb begin
    acc_d = acc_q;
    if (acc_clr) begin
      acc_d = ACC_INIT;
    end else if (accept && !comb_err) begin
      acc_d = comb_res;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      err_q   <= 1'b0;
      acc_q   <= ACC_INIT;
    end else begin
      valid_q <= valid_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      err_q   <= err_d;
      acc_q   <= acc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_res   = res_q;
  assign out_zero  = zero_q;
  assign out_err   = err_q;
  assign acc       = acc_q;

`ifdef LOGIC_UNIT_REG_STATS_EN
  logic [15:0] stat_ops_q, stat_ops_d;
  logic [15:0] stat_err_q, stat_err_d;

  always_comb begin
    stat_ops_d = stat_ops_q;
    stat_err_d = stat_err_q;
    if (accept && (stat_ops_q != 16'hFFFF)) begin
      stat_ops_d = stat_ops_q + 16'd1;
    end
    if (accept && comb_err && (stat_err_q != 16'hFFFF)) begin
      stat_err_d = stat_err_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops_q <= '0;
      stat_err_q <= '0;
    end else begin
      stat_ops_q <= stat_ops_d;
      stat_err_q <= stat_err_d;
    end
  end

  assign stat_ops = stat_ops_q;
  assign stat_err = stat_err_q;
`endif

endmodule

// File: tb/tb_logic_unit_reg.sv
// tb/tb_logic_unit_reg.sv - directed and randomized checks of logic_unit_reg against a behavioural model
module tb_logic_unit_reg;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [2:0]   in_op = 3'd0;
  logic         in_use_acc = 1'b0;
  logic [W-1:0] in_a = '0;
  logic [W-1:0] in_b = '0;
  logic         acc_clr = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] out_res;
  logic         out_zero;
  logic         out_err;
  logic [W-1:0] acc;
`ifdef LOGIC_UNIT_REG_STATS_EN
  logic [15:0]  stat_ops;
  logic [15:0]  stat_err;
`endif

  int checks = 0;
  int errors = 0;

  // Reference state: what the consumer should currently see.
  logic         m_valid = 1'b0;
  logic [W-1:0] m_res = '0;
  logic         m_zero = 1'b0;
  logic         m_err = 1'b0;
  logic [W-1:0] m_acc = '0;

  logic_unit_reg #(.WIDTH(W), .ACC_INIT(8'h00)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_use_acc (in_use_acc),
    .in_a       (in_a),
    .in_b       (in_b),
    .acc_clr    (acc_clr),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_res    (out_res),
    .out_zero   (out_zero),
    .out_err    (out_err),
    .acc        (acc)
`ifdef LOGIC_UNIT_REG_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_err   (stat_err)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_op(input int op, input logic [W-1:0] a, input logic [W-1:0] b);
    int ai, bi, r;
    ai = int'(a);
    bi = int'(b);
    case (op)
      0: r = 255 - (ai & bi);
      1: r = 255 - ai;
      2: r = ai & bi;
      3: r = ai | bi;
      4: r = ai ^ bi;
      5: r = bi;
      default: r = 0;
    endcase
    return r[W-1:0];
  endfunction

  task automatic set_in(input logic v, input int op, input logic ua, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic clr, input logic ordy);
    in_valid   = v;
    in_op      = op[2:0];
    in_use_acc = ua;
    in_a       = a;
    in_b       = b;
    acc_clr    = clr;
    out_ready  = ordy;
  endtask

  // Advance one clock and step the model with the inputs that were present at the edge.
  task automatic tick();
    logic         take;
    logic [W-1:0] opa, r;
    logic         rsv;
    take = in_valid && (!m_valid || out_ready);
    opa  = in_use_acc ? m_acc : in_a;
    r    = ref_op(int'(in_op), opa, in_b);
    rsv  = (int'(in_op) >= 6);
    @(posedge clk);
    #1;
    if (take) begin
      m_valid = 1'b1;
      m_res   = r;
      m_zero  = (r == 0);
      m_err   = rsv;
      if (!rsv) m_acc = r;
    end else if (m_valid && out_ready) begin
      m_valid = 1'b0;
    end
    if (acc_clr) m_acc = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_res, out_zero, out_err, acc} !== {1'b0, 8'h00, 1'b0, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL reset_state: got v=%b res=%h z=%b e=%b acc=%h, want 0 00 0 0 00",
               out_valid, out_res, out_zero, out_err, acc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    #2;
  endtask

  task automatic test_nand();
    set_in(1'b1, 0, 1'b0, 8'hF0, 8'h3C, 1'b0, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_res, out_zero, out_err, acc} !== {1'b1, 8'hCF, 1'b0, 1'b0, 8'hCF}) begin
      errors++;
      $display("FAIL nand: got v=%b res=%h z=%b e=%b acc=%h, want 1 CF 0 0 CF",
               out_valid, out_res, out_zero, out_err, acc);
    end
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] exp_res [3];
    int           ops [3];
    logic [W-1:0] bs [3];
    exp_res = '{8'h01, 8'hFE, 8'h00};
    ops     = '{3, 4, 2};
    bs      = '{8'h01, 8'hFF, 8'h00};
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b1, ops[i], 1'b1, 8'h55, bs[i], 1'b0, 1'b1);
      #1;
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_in_ready[%0d]: got %b want 1", i, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_res, out_zero, acc} !== {1'b1, exp_res[i], exp_res[i] == 8'h00, exp_res[i]}) begin
        errors++;
        $display("FAIL b2b[%0d]: got v=%b res=%h z=%b acc=%h, want res=%h", i,
                 out_valid, out_res, out_zero, acc, exp_res[i]);
      end
    end
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_stall();
    set_in(1'b1, 5, 1'b0, 8'h00, 8'hAA, 1'b0, 1'b0);
    tick();
    set_in(1'b1, 3, 1'b0, 8'h0F, 8'hF0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++;
      if (in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_in_ready[%0d]: got %b want 0", i, in_ready);
      end
      tick();
      checks++;
      if ({out_valid, out_res, acc} !== {1'b1, 8'hAA, 8'hAA}) begin
        errors++;
        $display("FAIL stall_hold[%0d]: got v=%b res=%h acc=%h, want 1 AA AA", i, out_valid, out_res, acc);
      end
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_release_ready: got %b want 1", in_ready);
    end
    tick();
    checks++;
    if ({out_valid, out_res, acc} !== {1'b1, 8'hFF, 8'hFF}) begin
      errors++;
      $display("FAIL stall_release: got v=%b res=%h acc=%h, want 1 FF FF", out_valid, out_res, acc);
    end
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_res} !== {1'b0, 8'hFF}) begin
      errors++;
      $display("FAIL drain_hold: got v=%b res=%h, want 0 FF", out_valid, out_res);
    end
  endtask

  task automatic test_reserved();
    logic [W-1:0] acc_before;
`ifdef LOGIC_UNIT_REG_STATS_EN
    logic [15:0] ops_before, err_before;
    ops_before = stat_ops;
    err_before = stat_err;
`endif
    acc_before = m_acc;
    set_in(1'b1, 6, 1'b0, 8'h12, 8'h34, 1'b0, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_res, out_zero, out_err, acc} !== {1'b1, 8'h00, 1'b1, 1'b1, acc_before}) begin
      errors++;
      $display("FAIL reserved: got v=%b res=%h z=%b e=%b acc=%h, want 1 00 1 1 %h",
               out_valid, out_res, out_zero, out_err, acc, acc_before);
    end
`ifdef LOGIC_UNIT_REG_STATS_EN
    checks++;
    if ({stat_ops, stat_err} !== {ops_before + 16'd1, err_before + 16'd1}) begin
      errors++;
      $display("FAIL reserved_stats: got ops=%0d err=%0d, want %0d %0d",
               stat_ops, stat_err, ops_before + 16'd1, err_before + 16'd1);
    end
`endif
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_acc_clr();
    set_in(1'b1, 5, 1'b0, 8'h00, 8'h5A, 1'b0, 1'b1);
    tick();
    set_in(1'b1, 1, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
    tick();
    checks++;
    if ({out_valid, out_res, out_err, acc} !== {1'b1, 8'hA5, 1'b0, 8'h00}) begin
      errors++;
      $display("FAIL acc_clr: got v=%b res=%h e=%b acc=%h, want 1 A5 0 00", out_valid, out_res, out_err, acc);
    end
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1);
    tick();
  endtask

  task automatic test_reset_mid_stall();
    set_in(1'b1, 5, 1'b0, 8'h00, 8'h77, 1'b0, 1'b0);
    tick();
    set_in(1'b0, 0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0);
    tick();
    checks++;
    if ({out_valid, out_res, acc} !== {1'b1, 8'h77, 8'h77}) begin
      errors++;
      $display("FAIL pre_reset_stall: got v=%b res=%h acc=%h, want 1 77 77", out_valid, out_res, acc);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, acc, out_res} !== {1'b0, 8'h00, 8'h00}) begin
      errors++;
      $display("FAIL async_reset: got v=%b acc=%h res=%h, want 0 00 00", out_valid, acc, out_res);
    end
    m_valid = 1'b0;
    m_res   = '0;
    m_zero  = 1'b0;
    m_err   = 1'b0;
    m_acc   = '0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), int'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             8'($urandom), 8'($urandom), ($urandom_range(0, 9) == 0), ($urandom_range(0, 2) != 0));
      #1;
      checks++;
      if (in_ready !== (!m_valid || out_ready)) begin
        errors++;
        $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, (!m_valid || out_ready));
      end
      tick();
      checks++;
      if ({out_valid, out_res, out_zero, out_err, acc} !== {m_valid, m_res, m_zero, m_err, m_acc}) begin
        errors++;
        $display("FAIL rand_out[%0d]: got v=%b res=%h z=%b e=%b acc=%h, want v=%b res=%h z=%b e=%b acc=%h", i,
                 out_valid, out_res, out_zero, out_err, acc, m_valid, m_res, m_zero, m_err, m_acc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_nand();
    test_back_to_back();
    test_stall();
    test_reserved();
    test_acc_clr();
    test_reset_mid_stall();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
